// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: default geometry
// and the add/subtract mode encoding.
package pipelined_cla_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_GROUP = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// One carry-lookahead group: per-bit sums plus group propagate/generate.
// The carry out is formed from the group P/G terms.
module cla_group
    import pipelined_cla_adder_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] bit_p;
    logic [GROUP-1:0] bit_g;
    logic [GROUP-1:0] carry;

    always_comb begin
        bit_p    = a ^ b;
        bit_g    = a & b;
        carry    = '0;
        carry[0] = c_in;
        for (int i = 0; i < GROUP - 1; i++) begin
            carry[i+1] = bit_g[i] | (bit_p[i] & carry[i]);
        end
        s = bit_p ^ carry;
        p = &bit_p;
        g = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            g = bit_g[i] | (bit_p[i] & g);
        end
        c_out = g | (p & c_in);
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one register stage per carry-lookahead group,
// with the remaining operand bits travelling alongside each partial result.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / GROUP;

    logic                          stall;
    logic                          advance;
    logic [STAGES-1:0]             valid_pipe;
    logic [STAGES-1:0]             carry_pipe;
    logic [STAGES-1:0]             grp_p;
    logic [STAGES-1:0]             grp_g;
    logic [STAGES-1:0][WIDTH-1:0]  a_pipe;
    logic [STAGES-1:0][WIDTH-1:0]  beff_pipe;
    logic [STAGES-1:0][WIDTH-1:0]  sum_pipe;
    logic                          last_a_msb;
    logic                          last_beff_msb;
    logic                          last_s_msb;
    logic                          ovf_reg;
    logic                          unused_tail;

    // A full output slot that is not taken freezes the whole pipe.
    assign stall    = valid_pipe[STAGES-1] & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] beff_in;
            logic [WIDTH-1:0] sum_in;
            logic [WIDTH-1:0] sum_next;
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] beff_reg;
            logic [WIDTH-1:0] sum_reg;
            logic [GROUP-1:0] s;
            logic             c_in;
            logic             c_out;
            logic             v_in;
            logic             valid_reg;
            logic             carry_reg;

            if (gi == 0) begin : g_head
                // Subtraction is a + ~b + 1, so the head carry is forced high.
                assign a_in    = a;
                assign beff_in = (sub == MODE_SUB) ? ~b : b;
                assign sum_in  = '0;
                assign c_in    = (sub == MODE_SUB) ? 1'b1 : cin;
                assign v_in    = in_valid;
            end else begin : g_body
                assign a_in    = a_pipe[gi-1];
                assign beff_in = beff_pipe[gi-1];
                assign sum_in  = sum_pipe[gi-1];
                assign c_in    = carry_pipe[gi-1];
                assign v_in    = valid_pipe[gi-1];
            end

            cla_group #(.GROUP(GROUP)) u_group (
                .a     (a_in[gi*GROUP +: GROUP]),
                .b     (beff_in[gi*GROUP +: GROUP]),
                .c_in  (c_in),
                .s     (s),
                .c_out (c_out),
                .p     (grp_p[gi]),
                .g     (grp_g[gi])
            );

            always_comb begin
                sum_next = sum_in;
                sum_next[gi*GROUP +: GROUP] = s;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    a_reg     <= '0;
                    beff_reg  <= '0;
                    sum_reg   <= '0;
                    carry_reg <= 1'b0;
                end else if (advance) begin
                    valid_reg <= v_in;
                    a_reg     <= a_in;
                    beff_reg  <= beff_in;
                    sum_reg   <= sum_next;
                    carry_reg <= c_out;
                end
            end

            assign valid_pipe[gi] = valid_reg;
            assign carry_pipe[gi] = carry_reg;
            assign a_pipe[gi]     = a_reg;
            assign beff_pipe[gi]  = beff_reg;
            assign sum_pipe[gi]   = sum_reg;

            if (gi == STAGES - 1) begin : g_tail
                assign last_a_msb    = a_in[WIDTH-1];
                assign last_beff_msb = beff_in[WIDTH-1];
                assign last_s_msb    = s[GROUP-1];
            end
        end
    endgenerate

    // Signed overflow: operands agree in sign but the result does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (advance) begin
            ovf_reg <= (last_a_msb == last_beff_msb) & (last_s_msb != last_a_msb);
        end
    end

    assign out_valid   = valid_pipe[STAGES-1];
    assign sum         = sum_pipe[STAGES-1];
    assign cout        = carry_pipe[STAGES-1];
    assign ovf         = ovf_reg;
    assign unused_tail = ^{a_pipe[STAGES-1], beff_pipe[STAGES-1], grp_p, grp_g};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: directed corner cases, a randomized stream
// with a mid-stream stall, and reset with transactions in flight.
module tb_pipelined_cla_adder;

    localparam int W      = 16;
    localparam int G      = 4;
    localparam int STAGES = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int pass_count  = 0;
    int check_count = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        int         sx;
        int         sy;
        int         r;
        logic [W:0] u;
        logic       o;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            r       = sx - sy;
            u[W]    = (x >= y);
            u[W-1:0] = x - y;
        end else begin
            r = sx + sy + int'(c);
            u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        end
        o = (r > 32767) || (r < -32768);
        return {o, u};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input logic s, input logic [W-1:0] exp_sum);
        logic [W+1:0] exp;
        int           lat;
        exp       = model(x, y, c, s);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = x; b = y; cin = c; sub = s;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_sum_model"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp[W+1]));
        $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, x, y, c, s, sum, cout, ovf, lat);
        tick();
        check({tag, "_no_dup"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] sa [10];
        logic [W-1:0] sb [10];
        logic         scin [10];
        logic         ssub [10];
        logic [W+1:0] q [$];
        logic [W+1:0] exp;
        logic [W+1:0] held;
        int           idx;
        int           got;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        run_one("inc", 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001);
        run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000);
        run_one("carry_in", 16'h0B0B, 16'h0606, 1'b1, 1'b0, 16'h1112);
        run_one("sub_pos", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002);
        run_one("sub_cin_ignored", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002);
        run_one("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE);
        run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF);

        // Randomized back-to-back stream with a three-cycle consumer stall.
        for (int i = 0; i < 10; i++) begin
            sa[i]   = W'($urandom);
            sb[i]   = W'($urandom);
            scin[i] = 1'($urandom);
            ssub[i] = 1'($urandom);
        end
        idx  = 0;
        got  = 0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (idx < 10);
            if (idx < 10) begin
                a = sa[idx]; b = sb[idx]; cin = scin[idx]; sub = ssub[idx];
            end
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                if (cyc > 6) check("stall_hold", 32'({ovf, cout, sum}), 32'(held));
            end
            held = {ovf, cout, sum};
            if (in_valid && in_ready) begin
                q.push_back(model(sa[idx], sb[idx], scin[idx], ssub[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_output", 32'(sum), 32'hFFFF_FFFF);
                end else begin
                    exp = q.pop_front();
                    check("stream_result", 32'({ovf, cout, sum}), 32'(exp));
                    $display("stream out %0d sum=%h cout=%0d ovf=%0d", got, sum, cout, ovf);
                end
                got++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_accepted", 32'(idx), 32'd10);
        check("stream_delivered", 32'(got), 32'd10);
        check("stream_queue_empty", 32'(q.size()), 32'd0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        $display("reset with transactions in flight applied");
        run_one("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            check("after_rst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; SHALL be a multiple of GROUP, minimum 4.
REQ-002 Parameter: GROUP, default 4, bits per carry-lookahead group; also the pipeline slice width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Pipeline depth SHALL be STAGES = WIDTH/GROUP, with one register stage per group.
REQ-016 Stage k SHALL compute group k (bits k*GROUP .. k*GROUP+GROUP-1) with generate/propagate lookahead logic from the carry registered by stage k-1.
  - Stage 0 uses cin, or 1 when sub=1.
REQ-017 Operand bits for groups above k SHALL be delayed alongside the partial result, so every pipeline slot carries one complete transaction.
REQ-018 Latency: a transfer accepted at edge N (in_valid & in_ready) SHALL appear with out_valid=1 after edge N+STAGES-1, provided there is no stall.
REQ-019 Stall = out_valid & ~out_ready.
  - While stalled, all pipeline registers SHALL hold.
  - in_ready = ~stall, combinational.
REQ-020 Throughput without stall SHALL be one transaction per cycle; back-to-back inputs SHALL produce back-to-back outputs in order.
REQ-021 Bubbles (in_valid=0 while ready) SHALL propagate as invalid slots; empty slots never raise out_valid.
REQ-022 ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
REQ-023 Arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-024 sum, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Inputs presented while in_ready=0 SHALL NOT be captured.

Reset
REQ-026 When rst=1 at a clock edge, all valid bits SHALL clear to 0 and sum, cout and ovf SHALL clear to 0.
  - out_valid reads 0 on the following cycle.
REQ-027 Reset mid-operation SHALL discard all in-flight transactions; no partial result is emitted afterward.
REQ-028 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-029 Datapath registers other than the outputs MAY be left unreset; only the valid bits gate correctness.

Structure
REQ-030 A shared package SHALL hold the default WIDTH and GROUP constants and the SUB/ADD mode encoding.
REQ-031 Group lookahead logic SHALL be a sub-module cla_group, parameterised by GROUP.
  - Inputs: a, b, c_in.
  - Outputs: s, c_out, plus group propagate/generate.
  - Instantiated STAGES times via generate.
REQ-032 The top level SHALL contain only the pipeline registers, the valid/stall control and the ovf logic.

Verification (WIDTH=16, GROUP=4, latency 4)
REQ-033 a=0x0001, b=0x0000, cin=0, sub=0 -> after 4 cycles: sum=0x0001, cout=0, ovf=0.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
  - Also a=0x0B0B, b=0x0606, cin=1 -> sum=0x1112.
REQ-035 sub=1, a=0x0005, b=0x0003 -> sum=0x0002, cout=1.
  - Also a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0.
  - Also a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
  - Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-036 Ten back-to-back random transactions, with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held, all ten results in order, none lost or duplicated.
REQ-037 Assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, no stale result thereafter.
  - A new transaction is accepted immediately and appears 4 cycles later.
